// File: rtl/spi_block_pkg.sv
// Shared constants and FSM state type for the SPI-to-register-bus bridge.
package spi_block_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int ADDR_W_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int RW_BIT          = 7;
    localparam logic CMD_WRITE     = 1'b1;

    typedef enum logic {
        ADDR,
        DATA
    } state_t;

endpackage

// File: rtl/spi_slave_byte.sv
// Oversampled SPI mode-3 slave byte engine: synchronizers, edge detect,
// RX shift with byte_done strobe, and TX shift register for read data.
module spi_slave_byte
    import spi_block_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mosi,
    input  logic              sclk,
    input  logic              ssel,
    input  logic              read_phase,
    input  logic [DATA_W-1:0] tx_data,
    output logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              byte_done
);

    localparam int CNT_W = $clog2(DATA_W);
    // Packed as {mosi, ssel, sclk}; bus idles with SCLK and SSEL high.
    localparam logic [2:0] SYNC_RST = 3'b011;

    logic [2:0]        sync_reg [SYNC_STAGES];
    logic              sclk_prev_reg;
    logic              ssel_prev_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic [DATA_W-1:0] rx_shift_reg;
    logic              byte_done_reg;
    logic [DATA_W-1:0] tx_shift_reg;
    logic              tx_active_reg;

    logic sclk_s, ssel_s, mosi_s;
    logic sclk_rise, sclk_fall, ssel_rise, ssel_fall;

    assign sclk_s    = sync_reg[SYNC_STAGES-1][0];
    assign ssel_s    = sync_reg[SYNC_STAGES-1][1];
    assign mosi_s    = sync_reg[SYNC_STAGES-1][2];
    assign sclk_rise =  sclk_s & ~sclk_prev_reg;
    assign sclk_fall = ~sclk_s &  sclk_prev_reg;
    assign ssel_rise =  ssel_s & ~ssel_prev_reg;
    assign ssel_fall = ~ssel_s &  ssel_prev_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= SYNC_RST;
            sclk_prev_reg <= 1'b1;
            ssel_prev_reg <= 1'b1;
        end else begin
            sync_reg[0] <= {mosi, ssel, sclk};
            for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
            sclk_prev_reg <= sclk_s;
            ssel_prev_reg <= ssel_s;
        end
    end

    // Any SSEL edge restarts the bit count, so a short frame is discarded.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt_reg   <= '0;
            rx_shift_reg  <= '0;
            byte_done_reg <= 1'b0;
        end else begin
            byte_done_reg <= 1'b0;
            if (ssel_fall || ssel_rise) begin
                bit_cnt_reg <= '0;
            end else if (sclk_rise && !ssel_s) begin
                rx_shift_reg <= {rx_shift_reg[DATA_W-2:0], mosi_s};
                if (bit_cnt_reg == CNT_W'(DATA_W - 1)) begin
                    bit_cnt_reg   <= '0;
                    byte_done_reg <= 1'b1;
                end else begin
                    bit_cnt_reg <= bit_cnt_reg + 1'b1;
                end
            end
        end
    end

    // The first falling edge of a frame keeps bit7 on the line; shifting
    // starts only once the master has sampled at least one bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_shift_reg  <= '0;
            tx_active_reg <= 1'b0;
        end else begin
            if (ssel_rise) tx_active_reg <= 1'b0;
            if (ssel_fall && read_phase) begin
                tx_shift_reg  <= tx_data;
                tx_active_reg <= 1'b1;
            end else if (sclk_fall && !ssel_s && bit_cnt_reg != '0) begin
                tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign miso      = tx_shift_reg[DATA_W-1] & tx_active_reg & ~ssel_s;
    assign rx_data   = rx_shift_reg;
    assign byte_done = byte_done_reg;

endmodule

// File: rtl/spi_block.sv
// SPI slave to register-bus bridge: two-byte frames (R/W+addr, data)
// become one-cycle write strobes or read data returned on MISO.
module spi_block
    import spi_block_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_MOSI,
    input  logic              i_SCLK,
    input  logic              i_SSEL,
    output logic              o_MISO,
    input  logic [DATA_W-1:0] i_data_read_bus,
    output logic [ADDR_W-1:0] o_addr_bus,
    output logic [DATA_W-1:0] o_data_write_bus,
    output logic              o_wr_enable_bus
);

    state_t            state_reg, state_next;
    logic              rw_reg, rw_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic              wr_reg, wr_next;

    logic [DATA_W-1:0] rx_data;
    logic              byte_done;
    logic              read_phase;

    assign read_phase = (state_reg == DATA) && (rw_reg != CMD_WRITE);

    spi_slave_byte #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_byte (
        .clk        (i_clk),
        .rst        (i_rst),
        .mosi       (i_MOSI),
        .sclk       (i_SCLK),
        .ssel       (i_SSEL),
        .read_phase (read_phase),
        .tx_data    (i_data_read_bus),
        .miso       (o_MISO),
        .rx_data    (rx_data),
        .byte_done  (byte_done)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_reg <= ADDR;
            rw_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            wr_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            rw_reg    <= rw_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            wr_reg    <= wr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rw_next    = rw_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        wr_next    = 1'b0;
        case (state_reg)
            ADDR: begin
                if (byte_done) begin
                    rw_next    = rx_data[RW_BIT];
                    addr_next  = ADDR_W'(rx_data[RW_BIT-1:0]);
                    state_next = DATA;
                end
            end
            DATA: begin
                if (byte_done) begin
                    if (rw_reg == CMD_WRITE) begin
                        wdata_next = rx_data;
                        wr_next    = 1'b1;
                    end
                    state_next = ADDR;
                end
            end
            default: state_next = ADDR;
        endcase
    end

    assign o_addr_bus       = addr_reg;
    assign o_data_write_bus = wdata_reg;
    assign o_wr_enable_bus  = wr_reg;

endmodule

// File: tb/tb_spi_block.sv
// Directed plus randomized SPI master bench for spi_block with a
// transaction-level model of expected bus writes and read data.
module tb_spi_block;

    localparam int HALF = 8;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_MOSI = 1'b0;
    logic       i_SCLK = 1'b1;
    logic       i_SSEL = 1'b1;
    logic       o_MISO;
    logic [7:0] i_data_read_bus;
    logic [7:0] o_addr_bus;
    logic [7:0] o_data_write_bus;
    logic       o_wr_enable_bus;

    logic [7:0] rf [128];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int run_len = 0;
    int max_run = 0;
    int st_cyc = 0;
    int last_rise_cyc = 0;
    logic [7:0] st_addr = 8'h00;
    logic [7:0] st_data = 8'h00;

    int exp_strobes = 0;
    logic [7:0] exp_addr = 8'h00;
    logic [7:0] exp_wdata = 8'h00;

    always #5 i_clk = ~i_clk;

    assign i_data_read_bus = rf[o_addr_bus[6:0]];

    spi_block dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_MOSI           (i_MOSI),
        .i_SCLK           (i_SCLK),
        .i_SSEL           (i_SSEL),
        .o_MISO           (o_MISO),
        .i_data_read_bus  (i_data_read_bus),
        .o_addr_bus       (o_addr_bus),
        .o_data_write_bus (o_data_write_bus),
        .o_wr_enable_bus  (o_wr_enable_bus)
    );

    always @(posedge i_clk) cyc++;

    // Strobe monitor: records each write strobe and its longest run.
    always @(posedge i_clk) begin
        #1;
        if (o_wr_enable_bus === 1'b1) begin
            strobe_cnt++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            st_addr = o_addr_bus;
            st_data = o_data_write_bus;
            st_cyc  = cyc;
        end else begin
            run_len = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        i_SSEL = 1'b0;
        tick(HALF);
        for (int i = 0; i < nbits; i++) begin
            i_SCLK = 1'b0;
            i_MOSI = tx[7-i];
            tick(HALF);
            rx = {rx[6:0], o_MISO};
            i_SCLK = 1'b1;
            last_rise_cyc = cyc;
            tick(HALF);
        end
        i_SSEL = 1'b1;
        i_MOSI = 1'b0;
        tick(2 * HALF);
    endtask

    task automatic txn(input logic [7:0] cmd, input logic [7:0] data);
        logic [7:0] r1;
        logic [7:0] r2;
        logic [7:0] exp_rd;
        spi_xfer(cmd, 8, r1);
        spi_xfer(data, 8, r2);
        exp_addr = {1'b0, cmd[6:0]};
        exp_rd   = 8'h00;
        if (cmd[7]) begin
            exp_wdata = data;
            exp_strobes++;
        end else begin
            exp_rd = rf[cmd[6:0]];
        end
        check("strobe_count", 32'(strobe_cnt), 32'(exp_strobes));
        check("addr_bus", 32'(o_addr_bus), 32'(exp_addr));
        check("write_bus", 32'(o_data_write_bus), 32'(exp_wdata));
        check("miso_addr_byte", 32'(r1), 32'h0);
        check("miso_data_byte", 32'(r2), 32'(exp_rd));
        check("miso_idle", 32'(o_MISO), 32'h0);
        if (cmd[7]) begin
            check("strobe_addr", 32'(st_addr), 32'(exp_addr));
            check("strobe_data", 32'(st_data), 32'(data));
            check("strobe_latency", 32'(st_cyc - last_rise_cyc <= 4), 32'h1);
        end
        $display("txn cmd=%02h data=%02h miso=%02h addr=%02h wdata=%02h strobes=%0d",
                 cmd, data, r2, o_addr_bus, o_data_write_bus, strobe_cnt);
    endtask

    initial begin
        logic [7:0] junk;
        for (int i = 0; i < 128; i++) rf[i] = 8'($urandom);
        rf[8'h0A] = 8'h15;
        rf[8'h02] = 8'h15;

        // Reset held ~10 us while the bus is active.
        i_rst  = 1'b0;
        i_SSEL = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (k % HALF == 0) i_SCLK = ~i_SCLK;
            i_MOSI = 1'($urandom);
            tick(1);
            if (k % 100 == 99) begin
                check("rst_addr", 32'(o_addr_bus), 32'h0);
                check("rst_wdata", 32'(o_data_write_bus), 32'h0);
                check("rst_wr", 32'(o_wr_enable_bus), 32'h0);
                check("rst_miso", 32'(o_MISO), 32'h0);
            end
        end
        check("rst_no_strobe", 32'(strobe_cnt), 32'h0);
        i_SSEL = 1'b1;
        i_SCLK = 1'b1;
        i_MOSI = 1'b0;
        tick(10);
        i_rst = 1'b1;
        tick(10);

        txn(8'hC2, 8'h02);
        txn(8'h0A, 8'hF1);
        txn(8'h02, 8'h01);
        txn(8'hF0, 8'h04);
        txn(8'hF3, 8'hFF);

        // Aborted address byte, then a full write.
        spi_xfer(8'h93, 4, junk);
        txn(8'hC5, 8'hAA);

        // Reset after an address byte only.
        spi_xfer(8'hC2, 8, junk);
        i_rst = 1'b0;
        tick(5);
        exp_addr  = 8'h00;
        exp_wdata = 8'h00;
        check("midrst_addr", 32'(o_addr_bus), 32'h0);
        check("midrst_wdata", 32'(o_data_write_bus), 32'h0);
        i_rst = 1'b1;
        tick(5);
        txn(8'h81, 8'h33);

        for (int n = 0; n < 24; n++) begin
            txn(8'($urandom), 8'($urandom));
        end

        check("strobe_width", 32'(max_run), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
